pixel_writer: RTL

PIXEL_WRITER -- requirements
Module: pixel_writer

---
 rtl/pixel_writer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/pixel_writer.sv
// rtl/pixel_writer.sv - Trigger-driven RGB pixel FIFO feeding a frame-buffer write port
// Optional feature macro: PIXWR_DROP_COUNT_EN (enables the saturating Drop_count counter)

module pixel_writer #(
    parameter int FRAME_PIXELS = 384000,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        theClock,
    input  logic        theReset_n,
    input  logic [7:0]  Red,
    input  logic [7:0]  Green,
    input  logic [7:0]  Blue,
    input  logic        Trigger,
    input  logic [7:0]  ImgNum,
    input  logic [7:0]  Config,
    output logic        wr_req,
    output logic [20:0] wr_addr,
    output logic [23:0] wr_data,
    input  logic        wr_wait,
    output logic [7:0]  Status,
    output logic [7:0]  Drop_count
);

    localparam int          AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [20:0] LAST_IDX = 21'(FRAME_PIXELS - 1);

    typedef enum logic {S_Idle, S_Write} state_t;

    state_t        state;
    logic          trig_q;
    logic          cfg1_q;
    logic [23:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          fifo_full;
    logic          overflow;
    logic          frame_done;
    logic [20:0]   pixel_index;
    logic [20:0]   base_q;

    logic          restart;
    logic          accept;
    logic          pop;
    logic          push;
    logic          drop;
    logic [23:0]   pix_in;
    logic [23:0]   next_head;
    logic [20:0]   idx_inc;
    logic [20:0]   idx_load;
    logic [20:0]   img_base;
    logic [20:0]   load_base;
    logic          unused_cfg;

    assign pix_in  = {Red, Green, Blue};
    assign restart = Config[1] & ~cfg1_q;
    // A pixel arriving together with a restart edge is discarded with the flushed FIFO
    assign accept  = Trigger & ~trig_q & Config[0] & ~restart;
    assign pop     = (state == S_Write) & ~wr_wait & ~restart;
    // A full FIFO still takes a pixel when the head leaves in the same cycle
    assign push    = accept & ((count != DEPTH_C) | pop);
    assign drop    = accept & ~push;

    assign count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

    // After a pop the new head is the next slot, unless the FIFO held one entry
    // and the incoming pixel is written this cycle (bypass the not-yet-written slot)
    assign next_head = ((count == (AW + 1)'(1)) && push) ? pix_in : mem[rd_ptr + AW'(1)];

    assign idx_inc   = (pixel_index == LAST_IDX) ? 21'd0 : pixel_index + 21'd1;
    assign idx_load  = (state == S_Write) ? idx_inc : pixel_index;
    assign img_base  = 21'(ImgNum[1:0]) * 21'(FRAME_PIXELS);
    // The frame base is latched only when the first pixel of a frame is issued
    assign load_base = (idx_load == 21'd0) ? img_base : base_q;

    assign Status     = {5'b0, frame_done, overflow, fifo_full};
    assign unused_cfg = &{1'b0, ImgNum[7:2], Config[7:2]};

    // Edge detectors and sticky status flags
    always_ff @(posedge theClock or negedge theReset_n) begin
        if (!theReset_n) begin
            trig_q     <= 1'b0;
            cfg1_q     <= 1'b0;
            overflow   <= 1'b0;
            frame_done <= 1'b0;
            fifo_full  <= 1'b0;
        end else begin
            trig_q <= Trigger;
            cfg1_q <= Config[1];
            if (restart) begin
                overflow   <= 1'b0;
                frame_done <= 1'b0;
                fifo_full  <= 1'b0;
            end else begin
                if (drop) begin
                    overflow <= 1'b1;
                end
                if (pop && (pixel_index == LAST_IDX)) begin
                    frame_done <= 1'b1;
                end
                fifo_full <= (count_next == DEPTH_C);
            end
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge theClock or negedge theReset_n) begin
        if (!theReset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (restart) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge theClock) begin
        if (push) begin
            mem[wr_ptr] <= pix_in;
        end
    end

    // Write-port FSM: present the FIFO head and advance the frame pixel index
    always_ff @(posedge theClock or negedge theReset_n) begin
        if (!theReset_n) begin
            state       <= S_Idle;
            wr_req      <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            pixel_index <= '0;
            base_q      <= '0;
        end else if (restart) begin
            state       <= S_Idle;
            wr_req      <= 1'b0;
            pixel_index <= '0;
        end else begin
            case (state)
                S_Idle: begin
                    if (count != '0) begin
                        state   <= S_Write;
                        wr_req  <= 1'b1;
                        wr_data <= mem[rd_ptr];
                        wr_addr <= load_base + pixel_index;
                        base_q  <= load_base;
                    end
                end
                S_Write: begin
                    if (pop) begin
                        pixel_index <= idx_inc;
                        if (count_next == '0) begin
                            state  <= S_Idle;
                            wr_req <= 1'b0;
                        end else begin
                            wr_data <= next_head;
                            wr_addr <= load_base + idx_inc;
                            base_q  <= load_base;
                        end
                    end
                end
                default: begin
                    state  <= S_Idle;
                    wr_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIXWR_DROP_COUNT_EN
    logic [7:0] drop_cnt;

    // Saturating count of pixels lost to a full FIFO
    always_ff @(posedge theClock or negedge theReset_n) begin
        if (!theReset_n) begin
            drop_cnt <= 8'h00;
        end else if (restart) begin
            drop_cnt <= 8'h00;
        end else if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'h01;
        end
    end

    assign Drop_count = drop_cnt;
`else
    assign Drop_count = 8'h00;
`endif

endmodule
